// File: rtl/trng_sample_ctrl.sv
// TRNG sample controller: gates and decimates the raw entropy source, discards a
// warm-up burst, runs a repetition-count health test and buffers bytes in a FWFT FIFO.
module trng_sample_ctrl #(
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP     = 16,
  parameter int REP_LIMIT  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear_fault,
  input  logic [7:0]               raw_in,
  output logic                     src_en,
  output logic [7:0]               rand_out,
  output logic                     rand_valid,
  input  logic                     rand_ready,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int WRM_W = $clog2(WARMUP + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARMUP - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WARMUP = 2'd1, S_RUN = 2'd2, S_FAULT = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WRM_W-1:0] warm_q, warm_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [7:0]       last_q, last_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];

  logic             active, strobe, rep_hit, stay_active, push, pop, flush;
  logic [REP_W-1:0] rep_upd;

  // Handshake: a byte leaves the FIFO on any cycle where rand_valid && rand_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      warm_q  <= '0;
      rep_q   <= '0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      warm_q  <= warm_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    active  = (state_q == S_WARMUP) || (state_q == S_RUN);
    strobe  = active && (div_q == DIV_LAST);
    if (raw_in != last_q)       rep_upd = REP_W'(1);
    else if (rep_q == REP_MAX)  rep_upd = rep_q;
    else                        rep_upd = rep_q + REP_W'(1);
    rep_hit = strobe && (rep_upd == REP_MAX);
  end

  // A failing sample wins over en=0 in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_WARMUP;
      S_WARMUP: begin
        if (rep_hit)                            state_d = S_FAULT;
        else if (!en)                           state_d = S_IDLE;
        else if (strobe && (warm_q == WRM_LAST)) state_d = S_RUN;
      end
      S_RUN: begin
        if (rep_hit)  state_d = S_FAULT;
        else if (!en) state_d = S_IDLE;
      end
      default:  if (clear_fault) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stay_active = active && ((state_d == S_WARMUP) || (state_d == S_RUN));
    div_d  = stay_active ? (strobe ? '0 : div_q + DIV_W'(1)) : '0;
    rep_d  = stay_active ? (strobe ? rep_upd : rep_q) : '0;
    last_d = strobe ? raw_in : last_q;
    warm_d = ((state_q == S_WARMUP) && (state_d == S_WARMUP))
             ? (strobe ? warm_q + WRM_W'(1) : warm_q) : '0;

    pop   = (cnt_q != '0) && rand_ready;
    flush = (state_q != S_FAULT) && (state_d == S_FAULT);
    push  = (state_q == S_RUN) && strobe && !rep_hit && ((cnt_q != LVL_FULL) || pop);

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Flush beats a coincident pop; pointers wrap naturally at DEPTH.
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) mem_d[wr_q] = raw_in;
      wr_d  = wr_q + PTR_W'(push);
      rd_d  = rd_q + PTR_W'(pop);
      cnt_d = cnt_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_comb begin
    src_en     = (state_q == S_WARMUP) || (state_q == S_RUN);
    fault      = (state_q == S_FAULT);
    rand_valid = (cnt_q != '0);
    rand_out   = rand_valid ? mem_q[rd_q] : 8'h00;
    level      = cnt_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl: a byte-queue scoreboard tracks FIFO contents
// while timed steps walk through warm-up, health fault, backpressure and stops.
module tb_trng_sample_ctrl;

  localparam int SDIV  = 4;
  localparam int WUP   = 16;
  localparam int DEPTH = 4;
  localparam logic [7:0] JUNK = 8'hC3;

  logic       clk = 1'b0;
  logic       rst, en, clear_fault, rand_ready;
  logic [7:0] raw_in;
  logic       src_en, rand_valid, fault;
  logic [7:0] rand_out;
  logic [2:0] level;
  logic [1:0] state;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  trng_sample_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clear_fault(clear_fault), .raw_in(raw_in),
    .src_en(src_en), .rand_out(rand_out), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .fault(fault), .level(level), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs already driven; checks the FIFO
  // outputs against the scoreboard, applies the coming edge to it, then advances.
  task automatic step(input bit push, input bit flush);
    bit pop;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("valid", 32'(rand_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("rand_out", 32'(rand_out), 32'(exp_q[0]));
    else                  chk("rand_out_empty", 32'(rand_out), 32'd0);
    pop = (exp_q.size() > 0) && rand_ready;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push && (exp_q.size() < DEPTH)) exp_q.push_back(raw_in);
    end
    @(negedge clk);
  endtask

  // From IDLE: enable and run the full warm-up; strobe values are base+index.
  task automatic warm_up(input logic [7:0] base);
    en = 1'b1;
    raw_in = JUNK;
    step(0, 0);
    for (int n = 0; n < SDIV * WUP; n++) begin
      chk("warm_state", 32'(state), 32'd1);
      chk("warm_src_en", 32'(src_en), 32'd1);
      raw_in = ((n % SDIV) == SDIV - 1) ? base + 8'(n / SDIV) : JUNK;
      step(0, 0);
    end
    raw_in = JUNK;
  endtask

  // One RUN sample period: SDIV-1 idle cycles, then the strobe cycle carrying v.
  task automatic run_strobe(input logic [7:0] v, input bit rdy_j, input bit rdy_s,
                            input bit push, input bit flush);
    rand_ready = rdy_j;
    raw_in = JUNK;
    for (int n = 0; n < SDIV - 1; n++) begin
      chk("run_state", 32'(state), 32'd2);
      step(0, 0);
    end
    chk("run_state", 32'(state), 32'd2);
    rand_ready = rdy_s;
    raw_in = v;
    step(push, flush);
    raw_in = JUNK;
    rand_ready = rdy_j;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clear_fault = 1'b0; rand_ready = 1'b0; raw_in = 8'h00;

    // Reset held two cycles with en high
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_src_en", 32'(src_en), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rand_valid), 32'd0);
    chk("rst_rand_out", 32'(rand_out), 32'd0);
    rst = 1'b0; en = 1'b0;
    step(0, 0);
    chk("idle_state", 32'(state), 32'd0);

    // Warm-up with incrementing bytes, first delivered byte is 0x10
    rand_ready = 1'b1;
    warm_up(8'h00);
    run_strobe(8'h10, 1, 1, 1, 0);
    chk("first_valid", 32'(rand_valid), 32'd1);
    chk("first_byte", 32'(rand_out), 32'h10);
    run_strobe(8'h11, 1, 1, 1, 0);
    en = 1'b0;
    step(0, 0);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_src_en", 32'(src_en), 32'd0);

    // Health fault on a stuck source
    raw_in = 8'hA5;
    en = 1'b1;
    step(0, 0);
    for (int n = 0; n < 4 * SDIV; n++) begin
      chk("hf_warm_state", 32'(state), 32'd1);
      step(0, n == 4 * SDIV - 1);
    end
    chk("hf_state", 32'(state), 32'd3);
    chk("hf_fault", 32'(fault), 32'd1);
    chk("hf_src_en", 32'(src_en), 32'd0);
    step(0, 0);
    chk("hf_en_ignored", 32'(state), 32'd3);
    clear_fault = 1'b1;
    step(0, 0);
    clear_fault = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    step(0, 0);
    chk("rewarm_state", 32'(state), 32'd1);
    chk("rewarm_src_en", 32'(src_en), 32'd1);
    en = 1'b0;
    step(0, 0);
    chk("rewarm_stop", 32'(state), 32'd0);

    // Backpressure: fill to 4, drop 0x35, then push+pop while full
    rand_ready = 1'b0;
    warm_up(8'h80);
    run_strobe(8'h31, 0, 0, 1, 0);
    run_strobe(8'h32, 0, 0, 1, 0);
    run_strobe(8'h33, 0, 0, 1, 0);
    run_strobe(8'h34, 0, 0, 1, 0);
    run_strobe(8'h35, 0, 0, 1, 0);
    chk("full_level", 32'(level), 32'd4);
    run_strobe(8'h36, 0, 1, 1, 0);
    chk("pushpop_level", 32'(level), 32'd4);
    en = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_state", 32'(state), 32'd0);

    // en dropped in RUN with two bytes buffered
    rand_ready = 1'b0;
    warm_up(8'h90);
    run_strobe(8'h41, 0, 0, 1, 0);
    run_strobe(8'h42, 0, 0, 1, 0);
    chk("en_drop_level", 32'(level), 32'd2);
    en = 1'b0;
    step(0, 0);
    chk("en_drop_state", 32'(state), 32'd0);
    chk("en_drop_src_en", 32'(src_en), 32'd0);
    rand_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("en_drop_drained", 32'(level), 32'd0);

    // Reset in RUN with three bytes buffered
    rand_ready = 1'b0;
    warm_up(8'hA0);
    run_strobe(8'h51, 0, 0, 1, 0);
    run_strobe(8'h52, 0, 0, 1, 0);
    run_strobe(8'h53, 0, 0, 1, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1;
    en = 1'b0;
    step(0, 0);
    rst = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(rand_valid), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    step(0, 0);

    // Fault in RUN with a full FIFO and a coincident pop: flush wins
    rand_ready = 1'b0;
    warm_up(8'hB0);
    run_strobe(8'h61, 0, 0, 1, 0);
    run_strobe(8'h62, 0, 0, 1, 0);
    run_strobe(8'h62, 0, 0, 1, 0);
    run_strobe(8'h62, 0, 0, 1, 0);
    chk("pre_fault_level", 32'(level), 32'd4);
    run_strobe(8'h62, 0, 1, 0, 1);
    chk("flush_state", 32'(state), 32'd3);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(rand_valid), 32'd0);
    en = 1'b0;
    clear_fault = 1'b1;
    step(0, 0);
    clear_fault = 1'b0;
    chk("final_state", 32'(state), 32'd0);
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trng_sample_ctrl.md
Name: trng_sample_ctrl

Overview:
- Controller sitting between the free-running TRNG entropy source (`trng`, 8-bit raw output) and the chip-level output pins.
- Gates the source on and off, decimates its raw byte stream, and discards a warm-up burst.
- Runs a repetition-count health test on every sample.
- Buffers accepted bytes in a small FIFO served over a valid/ready handshake; a health failure latches a fault until software clears it.

Parameters:
- SAMPLE_DIV, 4: clock cycles per raw sample strobe (>=2).
- WARMUP, 16: number of strobes discarded after each enable (>=1).
- REP_LIMIT, 4: consecutive identical samples that trigger a fault (>=2).
- DEPTH, 4: FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level enable; 1 = run the source.
- clear_fault  in  1  one-cycle pulse that leaves FAULT.
- raw_in  in  8  raw byte from the TRNG source.
- src_en  out  1  enable to the TRNG source.
- rand_out  out  8  FIFO head byte; 0 when empty.
- rand_valid  out  1  FIFO non-empty.
- rand_ready  in  1  consumer accepts the head byte.
- fault  out  1  health-test failure latched.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- state  out  2  IDLE=0, WARMUP=1, RUN=2, FAULT=3.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything: state IDLE, src_en 0, fault 0, level 0, rand_valid 0, rand_out 0, all counters 0, last_sample 0. rst has priority over every other input.
- src_en is registered and is 1 exactly while state is WARMUP or RUN.
- Divider: cleared on entry to WARMUP, then counts 0..SAMPLE_DIV-1 and wraps. The strobe is the cycle where the count equals SAMPLE_DIV-1. raw_in is sampled on that cycle. If entry happens at edge k, strobes fall at cycles k+SAMPLE_DIV-1, k+2*SAMPLE_DIV-1, and so on.
- Repetition test (WARMUP and RUN), evaluated on each strobe:
  - raw_in == last_sample: rep_cnt increments, saturating at REP_LIMIT.
  - otherwise: rep_cnt <= 1.
  - last_sample <= raw_in in both cases.
  - On WARMUP entry, rep_cnt = 0, so the first sample always yields rep_cnt 1.
  - If the updated rep_cnt reaches REP_LIMIT: state goes to FAULT at the next edge and that sample is not written.
- IDLE:
  - en=1 moves to WARMUP.
  - clear_fault is ignored.
- WARMUP:
  - Strobes are tested but never written.
  - After the WARMUP-th strobe, move to RUN; the divider continues without reset.
  - en=0 moves to IDLE.
- RUN:
  - Each passing strobe is pushed into the FIFO.
  - If the FIFO is full and no pop happens the same cycle, the sample is dropped silently; the test still updates.
  - en=0 moves to IDLE.
- FAULT:
  - On entry, the FIFO is flushed: level 0, rand_valid 0.
  - fault = 1, src_en = 0.
  - en is ignored.
  - clear_fault=1 moves to IDLE with fault 0. If en is still 1, the next cycle moves to WARMUP.
- Leaving to IDLE via en=0:
  - FIFO contents are kept and remain drainable.
  - Divider and rep_cnt are cleared.
  - Every re-enable repeats the full warm-up.
- FIFO behaviour:
  - First-word fall-through; rand_out = head entry.
  - A byte pushed on strobe cycle t is visible at rand_out / rand_valid from cycle t+1 when the FIFO was empty.
  - Pop occurs when rand_valid && rand_ready.
  - Push and pop in the same cycle: both happen, level unchanged, including when full.
  - Pointers wrap modulo DEPTH.
  - rand_ready while empty has no effect.
- Simultaneous events:
  - A fault strobe takes priority over en=0 that same cycle.
  - Flush-on-fault takes priority over a coincident pop.
- All outputs are registered or are pure decodes of registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset: hold rst for 2 cycles with en=1 -> state 0, src_en 0, fault 0, level 0, rand_valid 0, rand_out 0.
2. Warm-up and first byte (defaults), raw_in incrementing 0x00,0x01,… on each strobe, rand_ready=1:
   - en rises and WARMUP is entered at edge k -> src_en=1 from k; 16 strobes are discarded (k+3 … k+63).
   - Strobe 17 at k+67 carries 0x10 -> rand_valid=1 with rand_out=0x10 at k+68, and the byte is popped.
3. Health fault: raw_in held at 0xA5 -> 4th strobe (k+15) -> state FAULT, fault=1, src_en=0.
   - clear_fault pulse -> IDLE, fault=0; with en=1 held, WARMUP again the next cycle.
4. Backpressure: rand_ready=0 in RUN with distinct samples 0x31,0x32,0x33,0x34,0x35 -> level saturates at 4 and 0x35 is dropped.
   - Then rand_ready=1 -> outputs 0x31,0x32,0x33,0x34 in order, level reaches 0.
5. Full push+pop: level=4, rand_ready=1 on a strobe cycle -> level stays 4 and the new byte appears at the tail, read fifth.
6. Mid-operation stops:
   - en dropped in RUN with level=2 -> IDLE next edge, src_en=0, both bytes still drain.
   - rst asserted in RUN with level=3 -> level 0, rand_valid 0 next edge.
